// File: rtl/seq_math_unit.sv
// Iterative run-time math unit: floor/ceil division, ceiled log2 and index width.
// One shared shift/subtract datapath, one operation in flight, valid/ready on both sides.
module seq_math_unit #(
  parameter int Width    = 32,
  parameter int TagWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [1:0]          op_i,
  input  logic [Width-1:0]    a_i,
  input  logic [Width-1:0]    b_i,
  input  logic [TagWidth-1:0] tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    result_o,
  output logic [Width-1:0]    rem_o,
  output logic                div_zero_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                busy_o,
  output logic [1:0]          dbg_state_o
);

  localparam int CntW = $clog2(Width + 1);

  localparam logic [1:0] OpFloorDiv = 2'd0;
  localparam logic [1:0] OpCeilDiv  = 2'd1;
  localparam logic [1:0] OpIdxWidth = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    LOG  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [Width-1:0]    work_q, work_d;   // dividend->quotient shifter, or log operand n
  logic [Width-1:0]    dvsr_q, dvsr_d;
  logic [Width-1:0]    prem_q, prem_d;   // partial remainder, always < divisor
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TagWidth-1:0] tag_q, tag_d;
  logic [Width-1:0]    res_q, res_d;
  logic [Width-1:0]    rem_q, rem_d;
  logic                dz_q, dz_d;

  logic                accept;
  logic [Width:0]      trial;
  logic [Width:0]      diff;
  logic [Width:0]      prem_next;
  logic                ge;
  logic [Width-1:0]    quot_next;
  logic                last_iter;
  logic [Width-1:0]    cnt_ext;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and a raised out_valid_o holds until taken.
  assign in_ready_o  = (state_q == IDLE) & rst_ni;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign result_o    = res_q;
  assign rem_o       = rem_q;
  assign div_zero_o  = dz_q;
  assign tag_o       = tag_q;

  // One restoring step: the trial value carries an extra bit so the shift cannot overflow.
  always_comb begin
    trial     = {prem_q, work_q[Width-1]};
    ge        = (trial >= {1'b0, dvsr_q});
    diff      = trial - {1'b0, dvsr_q};
    prem_next = ge ? diff : trial;
    quot_next = {work_q[Width-2:0], ge};
    last_iter = (cnt_q == CntW'(Width - 1));
    cnt_ext   = Width'(cnt_q);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    res_d   = res_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op_i;
          tag_d  = tag_i;
          cnt_d  = '0;
          prem_d = '0;
          if (op_i == OpFloorDiv || op_i == OpCeilDiv) begin
            if (b_i == '0) begin
              res_d   = '1;
              rem_d   = a_i;
              dz_d    = 1'b1;
              state_d = DONE;
            end else begin
              work_d  = a_i;
              dvsr_d  = b_i;
              state_d = DIV;
            end
          end else begin
            work_d  = (a_i == '0) ? '0 : a_i - {{(Width-1){1'b0}}, 1'b1};
            state_d = LOG;
          end
        end
      end

      DIV: begin
        work_d = quot_next;
        prem_d = prem_next[Width-1:0];
        cnt_d  = cnt_q + 1'b1;
        if (last_iter) begin
          // Ceil rounding cannot wrap: a nonzero remainder implies divisor >= 2.
          res_d   = (op_q == OpCeilDiv && prem_next != '0)
                    ? quot_next + {{(Width-1){1'b0}}, 1'b1} : quot_next;
          rem_d   = prem_next[Width-1:0];
          dz_d    = 1'b0;
          state_d = DONE;
        end
      end

      LOG: begin
        if (work_q == '0) begin
          res_d   = (op_q == OpIdxWidth && cnt_q == '0)
                    ? {{(Width-1){1'b0}}, 1'b1} : cnt_ext;
          rem_d   = '0;
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          work_d = work_q >> 1;
          cnt_d  = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_seq_math_unit.sv
// Bench for seq_math_unit at Width=8: directed vector table, random model-checked
// requests, backpressure and mid-operation reset sequences.
module tb_seq_math_unit;

  localparam int W  = 8;
  localparam int TW = 4;

  localparam logic [1:0] OP_FLOOR = 2'd0;
  localparam logic [1:0] OP_CEIL  = 2'd1;
  localparam logic [1:0] OP_CLOG  = 2'd2;
  localparam logic [1:0] OP_IDX   = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [1:0]    op_i = '0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [W-1:0]  result_o;
  logic [W-1:0]  rem_o;
  logic          div_zero_o;
  logic [TW-1:0] tag_o;
  logic          busy_o;
  logic [1:0]    dbg_state_o;

  seq_math_unit #(.Width(W), .TagWidth(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .rem_o(rem_o), .div_zero_o(div_zero_o),
    .tag_o(tag_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard entries: {result, rem, div_zero, tag}
  logic [2*W+TW:0] exp_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic [W-1:0]  rem;
    logic          dz;
    int            lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model written from the arithmetic definitions.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic [W-1:0] rem,
                       output logic dz, output int lat);
    int ai, bi, k;
    ai = int'(a);
    bi = int'(b);
    if (op == OP_FLOOR || op == OP_CEIL) begin
      if (bi == 0) begin
        res = '1; rem = a; dz = 1'b1; lat = 1;
      end else begin
        res = (op == OP_FLOOR) ? W'(ai / bi) : W'((ai + bi - 1) / bi);
        rem = W'(ai % bi);
        dz  = 1'b0;
        lat = W + 1;
      end
    end else begin
      k = 0;
      while ((1 << k) < ai) k++;
      res = (op == OP_IDX && k == 0) ? W'(1) : W'(k);
      rem = '0;
      dz  = 1'b0;
      lat = k + 2;
    end
  endtask

  // Driver: called at a negedge with the unit idle; returns at a negedge, unit idle.
  task automatic run_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic [W-1:0] er,
                         input logic [W-1:0] erm, input logic edz, input int elat);
    int cyc;
    logic [2*W+TW:0] e;
    check("in_ready_before_req", in_ready_o, 1'b1);
    in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; tag_i = tag;
    exp_q.push_back({er, erm, edz, tag});
    @(negedge clk);
    in_valid_i = 1'b0;
    op_i  = 2'($urandom_range(0, 3));
    a_i   = W'($urandom_range(0, 255));
    b_i   = W'($urandom_range(0, 255));
    tag_i = TW'($urandom_range(0, 15));
    cyc = 1;
    while (!out_valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, elat);
    if (!out_valid_o) begin
      check("out_valid_timeout", 1'b0, 1'b1);
      void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check("unexpected_output", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check("result", result_o, e[2*W+TW:W+TW+1]);
      check("rem", rem_o, e[W+TW:TW+1]);
      check("div_zero", div_zero_o, e[TW]);
      check("tag", tag_o, e[TW-1:0]);
      check("in_ready_in_done", in_ready_o, 1'b0);
    end
    @(negedge clk);
    check("in_ready_after_hs", in_ready_o, 1'b1);
    check("out_valid_after_hs", out_valid_o, 1'b0);
  endtask

  initial begin
    logic [W-1:0] mr, mrem, ra, rb;
    logic [1:0]   rop;
    logic         mdz;
    int           mlat, cyc;

    vecs[0]  = '{OP_CEIL,  8'd7,   8'd2, 4'd3,  8'd4,   8'd1, 1'b0, 9};
    vecs[1]  = '{OP_FLOOR, 8'd7,   8'd2, 4'd3,  8'd3,   8'd1, 1'b0, 9};
    vecs[2]  = '{OP_FLOOR, 8'd255, 8'd1, 4'd1,  8'd255, 8'd0, 1'b0, 9};
    vecs[3]  = '{OP_CEIL,  8'd255, 8'd2, 4'd2,  8'd128, 8'd1, 1'b0, 9};
    vecs[4]  = '{OP_CEIL,  8'd0,   8'd5, 4'd4,  8'd0,   8'd0, 1'b0, 9};
    vecs[5]  = '{OP_FLOOR, 8'd9,   8'd0, 4'd5,  8'd255, 8'd9, 1'b1, 1};
    vecs[6]  = '{OP_FLOOR, 8'd100, 8'd7, 4'd6,  8'd14,  8'd2, 1'b0, 9};
    vecs[7]  = '{OP_CEIL,  8'd5,   8'd0, 4'd7,  8'd255, 8'd5, 1'b1, 1};
    vecs[8]  = '{OP_CLOG,  8'd5,   8'd9, 4'd8,  8'd3,   8'd0, 1'b0, 5};
    vecs[9]  = '{OP_CLOG,  8'd0,   8'd0, 4'd9,  8'd0,   8'd0, 1'b0, 2};
    vecs[10] = '{OP_CLOG,  8'd1,   8'd0, 4'd10, 8'd0,   8'd0, 1'b0, 2};
    vecs[11] = '{OP_CLOG,  8'd255, 8'd0, 4'd11, 8'd8,   8'd0, 1'b0, 10};
    vecs[12] = '{OP_IDX,   8'd1,   8'd0, 4'd12, 8'd1,   8'd0, 1'b0, 2};
    vecs[13] = '{OP_IDX,   8'd16,  8'd0, 4'd13, 8'd4,   8'd0, 1'b0, 6};
    vecs[14] = '{OP_IDX,   8'd0,   8'd3, 4'd14, 8'd1,   8'd0, 1'b0, 2};
    vecs[15] = '{OP_CLOG,  8'd128, 8'd0, 4'd15, 8'd7,   8'd0, 1'b0, 9};
    vecs[16] = '{OP_CLOG,  8'd129, 8'd0, 4'd0,  8'd8,   8'd0, 1'b0, 10};
    vecs[17] = '{OP_CEIL,  8'd200, 8'd255, 4'd1, 8'd1,  8'd200, 1'b0, 9};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready_low", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_result", result_o, '0);
    check("rst_rem", rem_o, '0);
    check("rst_div_zero", div_zero_o, 1'b0);
    check("rst_tag", tag_o, '0);
    check("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready_o, 1'b1);

    // directed table
    for (int i = 0; i < 18; i++)
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
              vecs[i].res, vecs[i].rem, vecs[i].dz, vecs[i].lat);

    // random requests against the model
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom_range(0, 255));
      rb  = (i % 5 == 0) ? W'(0) : W'($urandom_range(1, 255));
      model(rop, ra, rb, mr, mrem, mdz, mlat);
      run_req(rop, ra, rb, TW'(i), mr, mrem, mdz, mlat);
    end

    // backpressure: hold result for 10 cycles while stray requests are offered
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; op_i = OP_FLOOR; a_i = 8'd200; b_i = 8'd3; tag_i = 4'd5;
    @(negedge clk);
    in_valid_i = 1'b0;
    cyc = 1;
    while (!out_valid_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", cyc, 9);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid_o, 1'b1);
      check("bp_result", result_o, 8'd66);
      check("bp_rem", rem_o, 8'd2);
      check("bp_tag", tag_o, 4'd5);
      check("bp_in_ready", in_ready_o, 1'b0);
      in_valid_i = 1'b1; op_i = OP_CLOG; a_i = W'($urandom_range(0, 255)); tag_i = 4'd15;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    check("bp_hs_cycle_in_ready", in_ready_o, 1'b0);
    @(negedge clk);
    check("bp_release_in_ready", in_ready_o, 1'b1);
    check("bp_release_out_valid", out_valid_o, 1'b0);
    @(negedge clk);
    check("bp_stray_not_taken", busy_o, 1'b0);

    // reset in the middle of a division
    in_valid_i = 1'b1; op_i = OP_FLOOR; a_i = 8'd77; b_i = 8'd5; tag_i = 4'd9;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_div_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_o, 1'b0);
    check("abort_out_valid", out_valid_o, 1'b0);
    check("abort_in_ready_low", in_ready_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready_o, 1'b1);
    check("abort_result", result_o, '0);
    check("abort_tag", tag_o, '0);
    run_req(OP_FLOOR, 8'd77, 8'd5, 4'd9, 8'd15, 8'd2, 1'b0, 9);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
